// File: rtl/umi_arbiter_pkg.sv
// Shared types and helpers for umi_arbiter: FSM state enum, thermometer mask
// builder and one-hot-to-binary encoder.
package umi_arbiter_pkg;

   localparam int unsigned ARB_MAX_N = 32;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

   // Bits strictly above idx are set; idx = N-1 yields zero after truncation.
   function automatic logic [ARB_MAX_N-1:0] arb_thermo(input int unsigned idx);
      logic [ARB_MAX_N-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
         if (i > idx) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic int unsigned arb_oh2bin(input logic [ARB_MAX_N-1:0] oh);
      int unsigned b;
      b = 0;
      for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
         if (oh[i]) b = b | i;
      end
      return b;
   endfunction

endpackage

// File: rtl/umi_priority.sv
// Fixed-priority selector: one-hot grant of the lowest set request bit.
module umi_priority #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);

   assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/umi_arbiter.sv
// Transaction-locking arbiter for a shared UMI output port. Round-robin
// fairness is compiled in with UMI_ARBITER_ROUNDROBIN_EN; otherwise index 0 wins.
module umi_arbiter
   import umi_arbiter_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         umi_in_valid,
   input  logic [N-1:0]         umi_in_last,
   input  logic                 umi_out_ready,
   output logic [N-1:0]         umi_out_grant,
   output logic [$clog2(N)-1:0] umi_out_sel,
   output logic                 umi_out_valid,
   output logic                 busy
);

   localparam int unsigned SW = $clog2(N);

   arb_state_e   state_q, state_d;
   logic [N-1:0] held_q, held_d;
   logic [N-1:0] mask;
   logic [N-1:0] gnt_masked, gnt_raw, pick;
   logic         fire, fire_last;

   umi_priority #(.N(N)) u_pri_masked (
      .req_i (umi_in_valid & mask),
      .gnt_o (gnt_masked)
   );

   umi_priority #(.N(N)) u_pri_raw (
      .req_i (umi_in_valid),
      .gnt_o (gnt_raw)
   );

   assign pick      = (|gnt_masked) ? gnt_masked : gnt_raw;
   assign fire      = umi_out_valid & umi_out_ready;
   assign fire_last = fire & (|(umi_out_grant & umi_in_last));

`ifdef UMI_ARBITER_ROUNDROBIN_EN
   logic [N-1:0] mask_q, mask_d;

   always_comb begin
      mask_d = mask_q;
      if (fire_last) mask_d = N'(arb_thermo(int'(umi_out_sel)));
   end

   always_ff @(posedge clk) begin
      if (reset) mask_q <= '0;
      else       mask_q <= mask_d;
   end

   assign mask = mask_q;
`else
   assign mask = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         held_q  <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
      end
   end

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      case (state_q)
         ARB_IDLE: begin
            if (fire && !fire_last) begin
               state_d = ARB_LOCKED;
               held_d  = pick;
            end
         end
         ARB_LOCKED: begin
            if (fire_last) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Outputs are held at zero for any cycle with reset high, even mid-lock.
   always_comb begin
      umi_out_grant = '0;
      busy          = 1'b0;
      if (!reset) begin
         umi_out_grant = (state_q == ARB_LOCKED) ? held_q : pick;
         busy          = (state_q == ARB_LOCKED);
      end
      umi_out_sel   = SW'(arb_oh2bin(ARB_MAX_N'(umi_out_grant)));
      umi_out_valid = |(umi_out_grant & umi_in_valid);
   end

endmodule
